// File: rtl/mul_div_unit.sv
// mul_div_unit: execute-stage HI/LO multiply/divide unit.
// Runs mult/multu/div/divu over a fixed number of busy cycles, handles
// mthi/mtlo directly, and exposes the committed HI or LO value on out.
// Optional feature macro: MULDIV_FLUSH_EN adds a flush input that cancels a
// running operation and blocks acceptance of new starts in the same cycle.
module mul_div_unit #(
    parameter int unsigned MUL_LATENCY = 5,
    parameter int unsigned DIV_LATENCY = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MULDIV_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  ctrl,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        outputSel,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [2:0] MtMultiply         = 3'd1;
    localparam logic [2:0] MtMultiplyUnsigned = 3'd2;
    localparam logic [2:0] MtDivide           = 3'd3;
    localparam logic [2:0] MtDivideUnsigned   = 3'd4;
    localparam logic [2:0] MtSetHi            = 3'd5;
    localparam logic [2:0] MtSetLo            = 3'd6;

    localparam int unsigned MaxLat = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic [31:0]     op_a_q, op_b_q;
    logic [31:0]     hi_q, lo_q;
    logic            busy_q;

    logic            flush_w;
`ifdef MULDIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Arithmetic on the latched operands; one shared divider works on
    // magnitudes for the signed case so INT_MIN / -1 wraps cleanly.
    logic        div_signed, a_neg, b_neg;
    logic [31:0] dvd, dvs, quot, rem;
    logic [63:0] prod;
    logic [31:0] hi_res, lo_res;
    logic        res_we;
    always_comb begin
        div_signed = (op_q == MtDivide);
        a_neg      = div_signed & op_a_q[31];
        b_neg      = div_signed & op_b_q[31];
        dvd        = a_neg ? (~op_a_q + 32'd1) : op_a_q;
        dvs        = b_neg ? (~op_b_q + 32'd1) : op_b_q;
        quot       = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
        rem        = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
        if (op_q == MtMultiply) begin
            prod = {{32{op_a_q[31]}}, op_a_q} * {{32{op_b_q[31]}}, op_b_q};
        end else begin
            prod = {32'd0, op_a_q} * {32'd0, op_b_q};
        end
        hi_res = hi_q;
        lo_res = lo_q;
        res_we = 1'b0;
        case (op_q)
            MtMultiply, MtMultiplyUnsigned: begin
                hi_res = prod[63:32];
                lo_res = prod[31:0];
                res_we = 1'b1;
            end
            MtDivide, MtDivideUnsigned: begin
                // Divide by zero leaves HI/LO untouched.
                res_we = (op_b_q != 32'd0);
                lo_res = (a_neg ^ b_neg) ? (~quot + 32'd1) : quot;
                hi_res = a_neg ? (~rem + 32'd1) : rem;
            end
            default: res_we = 1'b0;
        endcase
    end

    // Control FSM with registered busy and committed HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            op_a_q  <= 32'd0;
            op_b_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !flush_w) begin
                        case (ctrl)
                            MtMultiply, MtMultiplyUnsigned, MtDivide, MtDivideUnsigned: begin
                                op_q    <= ctrl;
                                op_a_q  <= opA;
                                op_b_q  <= opB;
                                cnt_q   <= ((ctrl == MtMultiply) || (ctrl == MtMultiplyUnsigned))
                                           ? CntW'(MUL_LATENCY) : CntW'(DIV_LATENCY);
                                busy_q  <= 1'b1;
                                state_q <= StRun;
                            end
                            MtSetHi: hi_q <= opA;
                            MtSetLo: lo_q <= opA;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (flush_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            if (res_we) begin
                                hi_q <= hi_res;
                                lo_q <= lo_res;
                            end
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output mux always shows committed state.
    always_comb begin
        busy = busy_q;
        out  = outputSel ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: table-driven vectors with a scoreboard queue,
// plus hand-written sequences for ignored starts, reset abort and flush.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] opA, opB;
    logic        outputSel;
    logic        busy;
    logic [31:0] out;
`ifdef MULDIV_FLUSH_EN
    logic        flush;
`endif

    mul_div_unit #(.MUL_LATENCY(5), .DIV_LATENCY(10)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MULDIV_FLUSH_EN
        .flush    (flush),
`endif
        .start    (start),
        .ctrl     (ctrl),
        .opA      (opA),
        .opB      (opB),
        .outputSel(outputSel),
        .busy     (busy),
        .out      (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mhi, mlo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] c);
        if (c == 3'd1 || c == 3'd2) return 5;
        if (c == 3'd3 || c == 3'd4) return 10;
        return 0;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] u;
        sa = a;
        sb = b;
        case (c)
            3'd1: begin p = longint'(sa) * longint'(sb); return p; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one start pulse, scramble operands, count busy cycles (bounded).
    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1; ctrl = c; opA = a; opB = b;
        tick();
        start = 1'b0; ctrl = 3'd0; opA = $urandom; opB = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
    endtask

    task automatic check_res(input string nm, input int cyc);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({nm, "_sbq_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        chk({nm, "_busy_cycles"}, 32'(cyc), 32'(e.lat));
        outputSel = 1'b1; #1;
        chk({nm, "_hi"}, out, e.hi);
        outputSel = 1'b0; #1;
        chk({nm, "_lo"}, out, e.lo);
    endtask

    task automatic do_op(input string nm, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        logic [63:0] r;
        int          cyc;
        r = model(c, a, b, mhi, mlo);
        sbq.push_back('{r[63:32], r[31:0], lat_of(c)});
        mhi = r[63:32];
        mlo = r[31:0];
        run_op(c, a, b, cyc);
        check_res(nm, cyc);
    endtask

    initial begin
        int cyc;
        int rose;
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd6, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 0};
        vecs[4]  = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'h00001234, 10};
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[6]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[7]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[9]  = '{3'd0, 32'h0000AAAA, 32'h1,        32'h00000001, 32'h00000000, 0};
        vecs[10] = '{3'd7, 32'h0000BBBB, 32'h2,        32'h00000001, 32'h00000000, 0};
        vecs[11] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};

        reset = 1'b1; start = 1'b0; ctrl = 3'd0; opA = 32'd0; opB = 32'd0; outputSel = 1'b0;
`ifdef MULDIV_FLUSH_EN
        flush = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        outputSel = 1'b0; #1;
        chk("reset_lo", out, 32'd0);
        outputSel = 1'b1; #1;
        chk("reset_hi", out, 32'd0);

        // Table vectors; each start lands in the first idle cycle after the previous op.
        for (int i = 0; i < 12; i++) begin
            sbq.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].lat});
            run_op(vecs[i].c, vecs[i].a, vecs[i].b, cyc);
            check_res($sformatf("vec%0d", i), cyc);
        end
        mhi = vecs[11].hi;
        mlo = vecs[11].lo;

        // Back-to-back mthi then mtlo with start held high.
        start = 1'b1; ctrl = 3'd5; opA = 32'hDEADBEEF;
        tick();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        outputSel = 1'b1; #1;
        chk("mthi_hi", out, 32'hDEADBEEF);
        ctrl = 3'd6; opA = 32'd5;
        tick();
        start = 1'b0; ctrl = 3'd0;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        outputSel = 1'b0; #1;
        chk("mtlo_lo", out, 32'd5);
        outputSel = 1'b1; #1;
        chk("mtlo_hi", out, 32'hDEADBEEF);
        mhi = 32'hDEADBEEF;
        mlo = 32'd5;

        // Model-driven random operations.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (k % 2 == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            do_op($sformatf("rnd%0d", k), 3'(1 + k % 4), ra, rb);
        end

        // Start during busy is ignored; operand changes after the start edge are ignored.
        do_op("pre_a_hi", 3'd5, 32'h1111, 32'd0);
        start = 1'b1; ctrl = 3'd1; opA = 32'd2; opB = 32'd3;
        tick();
        start = 1'b0; ctrl = 3'd0;
        cyc = 1;
        tick();
        start = 1'b1; ctrl = 3'd5; opA = 32'h99;
        cyc++;
        tick();
        start = 1'b0; ctrl = 3'd0; opA = 32'h55; opB = 32'h77;
        outputSel = 1'b1; #1;
        chk("ign_hi_during_run", out, 32'h1111);
        cyc++;
        tick();
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        sbq.push_back('{32'd0, 32'd6, 5});
        check_res("ign_start", cyc);
        mhi = 32'd0;
        mlo = 32'd6;

        // Reset on busy cycle 3 of div 100/7 aborts; no late commit.
        do_op("pre_b_hi", 3'd5, 32'hAAAA, 32'd0);
        do_op("pre_b_lo", 3'd6, 32'hBBBB, 32'd0);
        start = 1'b1; ctrl = 3'd3; opA = 32'd100; opB = 32'd7;
        tick();
        start = 1'b0; ctrl = 3'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        outputSel = 1'b1; #1;
        chk("rst_abort_hi", out, 32'd0);
        outputSel = 1'b0; #1;
        chk("rst_abort_lo", out, 32'd0);
        rose = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (busy !== 1'b0) rose++;
        end
        chk("rst_no_busy", 32'(rose), 32'd0);
        outputSel = 1'b1; #1;
        chk("rst_no_commit_hi", out, 32'd0);
        outputSel = 1'b0; #1;
        chk("rst_no_commit_lo", out, 32'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        do_op("post_rst_div", 3'd3, 32'd100, 32'd7);

`ifdef MULDIV_FLUSH_EN
        // Flush on busy cycle 3 cancels; flush in idle blocks mthi.
        do_op("pre_f_hi", 3'd5, 32'hCAFE, 32'd0);
        do_op("pre_f_lo", 3'd6, 32'hF00D, 32'd0);
        start = 1'b1; ctrl = 3'd3; opA = 32'd100; opB = 32'd7;
        tick();
        start = 1'b0; ctrl = 3'd0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        rose = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (busy !== 1'b0) rose++;
        end
        chk("flush_no_busy", 32'(rose), 32'd0);
        outputSel = 1'b1; #1;
        chk("flush_hi", out, 32'hCAFE);
        outputSel = 1'b0; #1;
        chk("flush_lo", out, 32'hF00D);
        start = 1'b1; ctrl = 3'd5; opA = 32'h1; flush = 1'b1;
        tick();
        start = 1'b0; ctrl = 3'd0; flush = 1'b0;
        outputSel = 1'b1; #1;
        chk("flush_blocks_mthi", out, 32'hCAFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
